// File: rtl/axi_slv_rd_pkg.sv
// Shared AXI definitions for the read-slave slice: field widths, burst and
// response encodings, the AR request record held in the request queue, the
// beat FSM state type and the next-beat address helper (kept here so a future
// write slave computes burst addresses exactly the same way).
// No ports: package only.
package axi_slv_rd_pkg;

    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_USER_WIDTH  = 4;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_SIZE_WIDTH  = 3;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_RESP_WIDTH  = 2;

    // log2 of the bus width in bytes: the widest legal size and the word-index shift
    localparam int AXI_BYTES_LOG2 = $clog2(AXI_DATA_WIDTH / 8);

    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } beat_state_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_ADDR_WIDTH-1:0]  addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXI_SIZE_WIDTH-1:0]  size;
        logic [AXI_BURST_WIDTH-1:0] burst;
    } ar_req_t;

    // Address of the beat following 'addr'. Reserved burst encodings fall
    // through to INCR; such bursts are flagged SLVERR so the value is unused.
    function automatic logic [AXI_ADDR_WIDTH-1:0] axi_next_addr(
        input logic [AXI_ADDR_WIDTH-1:0]  addr,
        input logic [AXI_LEN_WIDTH-1:0]   len,
        input logic [AXI_SIZE_WIDTH-1:0]  size,
        input logic [AXI_BURST_WIDTH-1:0] burst
    );
        logic [AXI_ADDR_WIDTH-1:0] step;
        logic [AXI_ADDR_WIDTH-1:0] bnd;
        step = AXI_ADDR_WIDTH'(1) << size;
        bnd  = (AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size;
        case (burst)
            AXI_BURST_FIXED: axi_next_addr = addr;
            AXI_BURST_WRAP:  axi_next_addr = (addr & ~(bnd - AXI_ADDR_WIDTH'(1)))
                                           | ((addr + step) & (bnd - AXI_ADDR_WIDTH'(1)));
            default:         axi_next_addr = addr + step;
        endcase
    endfunction

endpackage

// File: rtl/axi_slv_rd_fifo.sv
// Synchronous FIFO used as the AR request queue.
// Ports: clk/rst_n (async active-low), push/push_data write side, pop/pop_data
// read side (pop_data shows the head combinationally), full/empty flags.
// A push while full is ignored; push and pop may happen on the same edge.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = store[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) store[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_slv_rd.sv
// AXI read slave with an internal word memory and a backdoor write port.
// AR requests are queued (OST_DEPTH deep) and answered in acceptance order as
// R bursts; FIXED/INCR/WRAP addressing with per-beat SLVERR/DECERR.
// Ports: clk, rst_n (async active-low); AR channel axi_slv_ar*; R channel
// axi_slv_r* (ruser tied to zero); backdoor mem_wr_en/mem_wr_addr/mem_wr_data.
module axi_slv_rd
    import axi_slv_rd_pkg::*;
#(
    parameter int OST_DEPTH = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI_ID_WIDTH-1:0]       axi_slv_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_slv_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]      axi_slv_arlen,
    input  logic [AXI_SIZE_WIDTH-1:0]     axi_slv_arsize,
    input  logic [AXI_BURST_WIDTH-1:0]    axi_slv_arburst,
    input  logic [AXI_USER_WIDTH-1:0]     axi_slv_aruser,
    input  logic                          axi_slv_arvalid,
    output logic                          axi_slv_arready,
    output logic [AXI_ID_WIDTH-1:0]       axi_slv_rid,
    output logic [AXI_DATA_WIDTH-1:0]     axi_slv_rdata,
    output logic [AXI_RESP_WIDTH-1:0]     axi_slv_rresp,
    output logic [AXI_USER_WIDTH-1:0]     axi_slv_ruser,
    output logic                          axi_slv_rlast,
    output logic                          axi_slv_rvalid,
    input  logic                          axi_slv_rready,
    input  logic                          mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]  mem_wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_wr_data
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);

    beat_state_t               state_q, state_d;
    ar_req_t                   push_req, q_head, cur, ld;
    logic [$bits(ar_req_t)-1:0] q_head_bits;
    logic                      q_full, q_empty, q_pop;
    logic                      load_first, load_next;
    logic [AXI_LEN_WIDTH-1:0]  beat_cnt, ld_cnt;
    logic [AXI_ADDR_WIDTH-1:0] ld_word;
    logic                      ld_slverr, ld_decerr;
    logic [AXI_DATA_WIDTH-1:0] ld_data;
    logic [AXI_RESP_WIDTH-1:0] ld_resp;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                      unused_aruser;

    assign unused_aruser   = ^axi_slv_aruser;
    assign axi_slv_ruser   = '0;
    assign axi_slv_arready = !q_full;
    assign axi_slv_rvalid  = (state_q == ST_BURST);

    assign push_req = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                        size: axi_slv_arsize, burst: axi_slv_arburst};
    assign q_head   = ar_req_t'(q_head_bits);

    axi_sync_fifo #(
        .WIDTH ($bits(ar_req_t)),
        .DEPTH (OST_DEPTH)
    ) u_ar_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (axi_slv_arvalid && axi_slv_arready),
        .push_data (push_req),
        .pop       (q_pop),
        .pop_data  (q_head_bits),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // In BURST rvalid is always high, so rready alone is the handshake. The
    // last beat chains straight into the next queued burst without a bubble.
    always_comb begin
        state_d    = state_q;
        q_pop      = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    load_first = 1'b1;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (axi_slv_rready) begin
                    if (!axi_slv_rlast) begin
                        load_next = 1'b1;
                    end else if (!q_empty) begin
                        q_pop      = 1'b1;
                        load_first = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Describe the beat to be loaded: either beat 0 of the queue head or the
    // successor of the beat currently presented. Errors are judged per beat.
    always_comb begin
        ld     = cur;
        ld_cnt = beat_cnt;
        if (load_first) begin
            ld     = q_head;
            ld_cnt = '0;
        end else if (load_next) begin
            ld.addr = axi_next_addr(cur.addr, cur.len, cur.size, cur.burst);
            ld_cnt  = beat_cnt + AXI_LEN_WIDTH'(1);
        end
        ld_word   = ld.addr >> AXI_BYTES_LOG2;
        ld_slverr = (ld.size > AXI_SIZE_WIDTH'(AXI_BYTES_LOG2))
                 || (ld.burst == 2'b11)
                 || ((ld.burst == AXI_BURST_WRAP)
                     && !((ld.len == 8'd1) || (ld.len == 8'd3) || (ld.len == 8'd7) || (ld.len == 8'd15)));
        ld_decerr = (ld_word >= AXI_ADDR_WIDTH'(MEM_DEPTH));
        ld_data   = '0;
        ld_resp   = AXI_RESP_OKAY;
        if (ld_slverr) begin
            ld_resp = AXI_RESP_SLVERR;
        end else if (ld_decerr) begin
            ld_resp = AXI_RESP_DECERR;
        end else begin
            ld_data = mem[ld_word[MEM_AW-1:0]];
        end
    end

    // R payload registers: change only on a beat load, so a stalled beat is
    // held stable and later backdoor writes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur           <= '0;
            beat_cnt      <= '0;
            axi_slv_rid   <= '0;
            axi_slv_rdata <= '0;
            axi_slv_rresp <= AXI_RESP_OKAY;
            axi_slv_rlast <= 1'b0;
        end else if (load_first || load_next) begin
            cur           <= ld;
            beat_cnt      <= ld_cnt;
            axi_slv_rid   <= ld.id;
            axi_slv_rdata <= ld_data;
            axi_slv_rresp <= ld_resp;
            axi_slv_rlast <= (ld_cnt == ld.len);
        end else if ((state_q == ST_BURST) && (state_d == ST_IDLE)) begin
            axi_slv_rlast <= 1'b0;
        end
    end

    // Backdoor memory, not reset. A load on the same edge reads the old word.
    always_ff @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

endmodule
